// File: rtl/icache_pkg.sv
// icache_pkg: shared fetch-path types and address field widths
package icache_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DONE} ic_state_e;
  localparam int OFF_W = 2;
  localparam int LINES_DEF = 128;
  localparam int ADDR_W_DEF = 32;
  function automatic int idx_w(int lines);
    return $clog2(lines);
  endfunction
  function automatic int tag_w(int addr_w, int lines);
    return addr_w - OFF_W - $clog2(lines);
  endfunction
  localparam int IDX_W = idx_w(LINES_DEF);
  localparam int TAG_W = tag_w(ADDR_W_DEF, LINES_DEF);
endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-side request/response and byte-wide memory port
interface icache_if #(parameter int ADDR_W = 32);
  logic              if_req;
  logic [ADDR_W-1:0] if_pc;
  logic              flush;
  logic              ic_ok;
  logic [31:0]       ic_dt;
  logic              ic_hit;
  logic              ic_busy;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_rd;
  logic              mem_gnt;
  logic [7:0]        mem_din;
  modport master (output if_req, if_pc, flush, mem_gnt, mem_din,
                  input ic_ok, ic_dt, ic_hit, ic_busy, mem_a, mem_rd);
  modport slave (input if_req, if_pc, flush, mem_gnt, mem_din,
                 output ic_ok, ic_dt, ic_hit, ic_busy, mem_a, mem_rd);
endinterface

// File: rtl/icache_tagarr.sv
// icache_tagarr: valid/tag/data flop array, async read, sync write and clear
module icache_tagarr #(
  parameter int LINES = 128,
  parameter int TW = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(LINES)-1:0] ridx,
  output logic                     rv,
  output logic [TW-1:0]            rtag,
  output logic [31:0]              rdata,
  input  logic                     we,
  input  logic [$clog2(LINES)-1:0] widx,
  input  logic [TW-1:0]            wtag,
  input  logic [31:0]              wdata
);
  logic [LINES-1:0] v_q;
  logic [TW-1:0]    tag_q [LINES];
  logic [31:0]      data_q [LINES];
  assign rv = v_q[ridx];
  assign rtag = tag_q[ridx];
  assign rdata = data_q[ridx];
  always_ff @(posedge clk) begin
    if (rst) v_q <= '0;
    else if (we) v_q[widx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      tag_q[widx] <= wtag;
      data_q[widx] <= wdata;
    end
  end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped one-word-line instruction cache with byte-serial refill
module icache import icache_pkg::*; #(
  parameter int LINES = 128,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst,
  icache_if.slave b
);
  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(ADDR_W, LINES);
  ic_state_e st_q, st_d;
  logic [ADDR_W-3:0] pc_q, pc_d;
  logic [1:0] k_q, k_d, pk_q, pk_d;
  logic pend_q, pend_d;
  logic [31:0] word_q, word_d, dt_q, dt_d;
  logic ok_q, ok_d, hit_q, hit_d, rd_q, rd_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic rv, fv, fw, we, acc, hit;
  logic [TW-1:0] rtag, ftag;
  logic [31:0] rdata, fdata;
  logic unused_pc;
  assign unused_pc = ^b.if_pc[1:0];
  icache_tagarr #(.LINES(LINES), .TW(TW)) u_arr (
    .clk(clk), .rst(rst),
    .ridx(b.if_pc[IW+1:2]), .rv(rv), .rtag(rtag), .rdata(rdata),
    .we(we), .widx(pc_q[IW-1:0]), .wtag(pc_q[ADDR_W-3:IW]), .wdata(word_q)
  );
  // forward the line being written so a request in the DONE cycle sees it
  assign we = (st_q == DONE) & ~b.flush;
  assign fw = we & (pc_q[IW-1:0] == b.if_pc[IW+1:2]);
  assign fv = fw | rv;
  assign ftag = fw ? pc_q[ADDR_W-3:IW] : rtag;
  assign fdata = fw ? word_q : rdata;
  assign hit = fv & (ftag == b.if_pc[ADDR_W-1:IW+2]);
  assign acc = b.if_req & ~b.flush & (st_q != FILL);
  always_comb begin
    st_d = st_q;
    pc_d = pc_q;
    k_d = k_q;
    pk_d = k_q;
    pend_d = rd_q & b.mem_gnt;
    word_d = word_q;
    if (pend_q) word_d[{pk_q, 3'b000} +: 8] = b.mem_din;
    ok_d = 1'b0;
    hit_d = hit_q;
    dt_d = dt_q;
    rd_d = 1'b0;
    a_d = a_q;
    if (st_q == FILL) begin
      rd_d = rd_q & ~(b.mem_gnt & (k_q == 2'd3));
      if (rd_q & b.mem_gnt & (k_q != 2'd3)) begin
        k_d = k_q + 2'd1;
        a_d = {pc_q, k_q + 2'd1};
      end
      if (pend_q & (pk_q == 2'd3)) begin
        st_d = DONE;
        ok_d = 1'b1;
        hit_d = 1'b0;
        dt_d = word_d;
      end
    end else begin
      st_d = IDLE;
      if (acc & hit) begin
        ok_d = 1'b1;
        hit_d = 1'b1;
        dt_d = fdata;
      end else if (acc) begin
        st_d = FILL;
        pc_d = b.if_pc[ADDR_W-1:2];
        k_d = 2'd0;
        rd_d = 1'b1;
        a_d = {b.if_pc[ADDR_W-1:2], 2'b00};
      end
    end
    // redirect drops the request, the refill and any byte still in flight
    if (b.flush) begin
      st_d = IDLE;
      rd_d = 1'b0;
      pend_d = 1'b0;
      ok_d = 1'b0;
      hit_d = hit_q;
      dt_d = dt_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      pc_q <= '0;
      k_q <= 2'd0;
      pk_q <= 2'd0;
      pend_q <= 1'b0;
      word_q <= '0;
      dt_q <= '0;
      ok_q <= 1'b0;
      hit_q <= 1'b0;
      rd_q <= 1'b0;
      a_q <= '0;
    end else begin
      st_q <= st_d;
      pc_q <= pc_d;
      k_q <= k_d;
      pk_q <= pk_d;
      pend_q <= pend_d;
      word_q <= word_d;
      dt_q <= dt_d;
      ok_q <= ok_d;
      hit_q <= hit_d;
      rd_q <= rd_d;
      a_q <= a_d;
    end
  end
  assign b.ic_ok = ok_q & ~(b.flush & (st_q == DONE));
  assign b.ic_hit = hit_q;
  assign b.ic_dt = dt_q;
  assign b.ic_busy = (st_q == FILL);
  assign b.mem_rd = rd_q;
  assign b.mem_a = a_q;
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed checks of hit/miss/stall/flush/reset behaviour
module tb_icache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  int lat;
  int seen;
  icache_if #(.ADDR_W(32)) bus ();
  icache #(.LINES(128), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .b(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] mbyte(input logic [31:0] a);
    case (a)
      32'h10: return 8'h13;
      32'h11: return 8'h05;
      32'h12: return 8'h10;
      32'h13: return 8'h00;
      default: return a[7:0] + 8'h40;
    endcase
  endfunction
  always @(posedge clk) bus.mem_din <= (bus.mem_rd && bus.mem_gnt) ? mbyte(bus.mem_a) : 8'h00;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [31:0] pc);
    bus.if_req = 1'b1;
    bus.if_pc = pc;
    tick();
    bus.if_req = 1'b0;
  endtask
  task automatic wait_ok(input int start, output int l);
    l = start;
    while (!bus.ic_ok && l < 40) begin
      tick();
      l++;
    end
  endtask
  task automatic quiet(input int n, output int s);
    s = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.ic_ok) s++;
      tick();
    end
  endtask
  initial begin
    bus.if_req = 1'b0;
    bus.if_pc = '0;
    bus.flush = 1'b0;
    bus.mem_gnt = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ok", bus.ic_ok, 0);
    chk("rst_hit", bus.ic_hit, 0);
    chk("rst_dt", bus.ic_dt, 0);
    chk("rst_busy", bus.ic_busy, 0);
    chk("rst_rd", bus.mem_rd, 0);
    chk("rst_a", bus.mem_a, 0);
    tick();
    // cold miss at 0x10
    req(32'h10);
    for (int i = 0; i < 4; i++) begin
      chk("cold_rd", bus.mem_rd, 1);
      chk("cold_a", bus.mem_a, 32'h10 + i);
      chk("cold_busy", bus.ic_busy, 1);
      chk("cold_ok_early", bus.ic_ok, 0);
      tick();
    end
    chk("cold_cap_rd", bus.mem_rd, 0);
    chk("cold_cap_ok", bus.ic_ok, 0);
    tick();
    chk("cold_ok", bus.ic_ok, 1);
    chk("cold_hit", bus.ic_hit, 0);
    chk("cold_dt", bus.ic_dt, 32'h0010_0513);
    chk("cold_busy_done", bus.ic_busy, 0);
    tick();
    // hit on the freshly filled line, then two back-to-back hits
    req(32'h10);
    chk("hit_ok", bus.ic_ok, 1);
    chk("hit_hit", bus.ic_hit, 1);
    chk("hit_dt", bus.ic_dt, 32'h0010_0513);
    chk("hit_rd", bus.mem_rd, 0);
    chk("hit_busy", bus.ic_busy, 0);
    tick();
    chk("hold_ok", bus.ic_ok, 0);
    chk("hold_dt", bus.ic_dt, 32'h0010_0513);
    bus.if_req = 1'b1;
    bus.if_pc = 32'h10;
    tick();
    chk("b2b_ok0", bus.ic_ok, 1);
    tick();
    bus.if_req = 1'b0;
    chk("b2b_ok1", bus.ic_ok, 1);
    chk("b2b_hit1", bus.ic_hit, 1);
    tick();
    // conflicting tag on the same index evicts 0x10
    req(32'h210);
    wait_ok(1, lat);
    chk("conf_lat", lat, 6);
    chk("conf_hit", bus.ic_hit, 0);
    chk("conf_dt", bus.ic_dt, 32'h5352_5150);
    tick();
    // 0x10 misses again, with a 3-cycle grant stall at k=2
    req(32'h10);
    tick();
    tick();
    bus.mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_a", bus.mem_a, 32'h12);
      chk("stall_rd", bus.mem_rd, 1);
      tick();
    end
    bus.mem_gnt = 1'b1;
    chk("stall_a_rel", bus.mem_a, 32'h12);
    wait_ok(6, lat);
    chk("stall_lat", lat, 9);
    chk("stall_hit", bus.ic_hit, 0);
    chk("stall_dt", bus.ic_dt, 32'h0010_0513);
    tick();
    // flush at k=1 of a 0x210 refill
    req(32'h210);
    tick();
    chk("fl_a", bus.mem_a, 32'h211);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fl_busy", bus.ic_busy, 0);
    chk("fl_rd", bus.mem_rd, 0);
    quiet(5, seen);
    chk("fl_no_ok", seen, 0);
    req(32'h210);
    wait_ok(1, lat);
    chk("fl_remiss_lat", lat, 6);
    chk("fl_remiss_hit", bus.ic_hit, 0);
    chk("fl_remiss_dt", bus.ic_dt, 32'h5352_5150);
    tick();
    // flush with a hitting request drops the response
    bus.if_req = 1'b1;
    bus.if_pc = 32'h210;
    bus.flush = 1'b1;
    tick();
    bus.if_req = 1'b0;
    bus.flush = 1'b0;
    chk("fl_idle_ok", bus.ic_ok, 0);
    chk("fl_idle_rd", bus.mem_rd, 0);
    // reset at k=3 of a 0x20 refill; 0x210 line must be gone
    req(32'h20);
    tick();
    tick();
    tick();
    chk("rk3_a", bus.mem_a, 32'h23);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rk3_ok", bus.ic_ok, 0);
    chk("rk3_hit", bus.ic_hit, 0);
    chk("rk3_dt", bus.ic_dt, 0);
    chk("rk3_busy", bus.ic_busy, 0);
    chk("rk3_rd", bus.mem_rd, 0);
    chk("rk3_a0", bus.mem_a, 0);
    quiet(4, seen);
    chk("rk3_no_ok", seen, 0);
    req(32'h210);
    wait_ok(1, lat);
    chk("rk3_miss_lat", lat, 6);
    chk("rk3_miss_hit", bus.ic_hit, 0);
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
